// File: rtl/pkt_rx_classifier.sv
// Receive-side classifier: buffers the Ethernet header in a delay line, decides
// NMAC/PTP/other admission and TSN class, truncates or drops bad frames, keeps statistics.
module pkt_rx_classifier #(
  parameter int          DW        = 8,
  parameter int          TS_W      = 19,
  parameter int          HDR_LEN   = 14,
  parameter int          MAX_LEN   = 2048,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] NMAC_TYPE = 16'h1662,
  parameter logic [15:0] PTP_TYPE  = 16'h88F7
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            port_type,
  input  logic [1:0]      cfg_finish,
  input  logic [DW:0]     iv_data,
  input  logic            i_data_wr,
  input  logic [TS_W-1:0] iv_timer,
  output logic [DW:0]     ov_data,
  output logic            o_data_wr,
  output logic [TS_W-1:0] ov_rec_ts,
  output logic            o_tsn_en,
  output logic            o_pkt_valid_pulse,
  output logic            o_pkt_drop_pulse,
  output logic [CNT_W-1:0] ov_accept_cnt,
  output logic [CNT_W-1:0] ov_drop_cnt,
  output logic [CNT_W-1:0] ov_err_cnt,
  output logic [1:0]      ov_state
);

  localparam int WC_W = $clog2(MAX_LEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  logic [DW:0]        r_sl_data [HDR_LEN];
  logic [HDR_LEN-1:0] r_sl_vld;
  logic [HDR_LEN-1:0] r_sl_pass;
  logic [HDR_LEN-1:0] r_sl_force;
  logic [HDR_LEN-1:0] r_sl_sof;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WC_W-1:0]  r_wcnt;
  logic [WC_W-1:0]  w_wcnt_nxt;
  logic [WC_W-1:0]  w_wcnt_inc;
  logic [TS_W-1:0]  r_ts_pend;
  logic [TS_W-1:0]  r_rec_ts;
  logic             r_tsn;
  logic [7:0]       r_byte0;
  logic [7:0]       r_et_hi;
  logic [7:0]       r_et_lo;
  logic             r_drop_pulse;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic        w_flag;
  logic [15:0] w_etype;
  logic        w_decide;
  logic        w_accept;
  logic        w_tsn;
  logic        w_store;
  logic        w_pass_new;
  logic        w_sof_new;
  logic        w_force_new;
  logic        w_force_prev;
  logic        w_tag_all;
  logic        w_decide_acc;
  logic        w_take_ts;
  logic        w_drop;
  logic        w_err;
  logic        w_out_vld;
  logic        w_out_flag;
  logic        w_out_eof;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_flag     = iv_data[DW];
  assign w_wcnt_inc = r_wcnt + 1'b1;
  // With the minimum header depth the EtherType low byte arrives on the decision word itself.
  assign w_etype    = {r_et_hi, (r_wcnt == WC_W'(13)) ? iv_data[7:0] : r_et_lo};
  assign w_decide   = (r_state == S_HEAD) && i_data_wr && (r_wcnt == WC_W'(HDR_LEN-1));
  assign w_accept   = (w_etype == NMAC_TYPE) || ((w_etype == PTP_TYPE) && (cfg_finish != 2'b00))
                      || cfg_finish[1];
  assign w_tsn      = port_type ? (w_etype == 16'h8100) : r_byte0[7];

  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_store      = 1'b0;
    w_pass_new   = 1'b0;
    w_sof_new    = 1'b0;
    w_force_new  = 1'b0;
    w_force_prev = 1'b0;
    w_tag_all    = 1'b0;
    w_decide_acc = 1'b0;
    w_take_ts    = 1'b0;
    w_drop       = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_data_wr && w_flag) begin
          w_store     = 1'b1;
          w_sof_new   = 1'b1;
          w_take_ts   = 1'b1;
          w_wcnt_nxt  = WC_W'(1);
          w_state_nxt = S_HEAD;
        end
      end
      S_HEAD: begin
        if (!i_data_wr) begin
          w_drop      = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_store    = 1'b1;
          w_wcnt_nxt = w_wcnt_inc;
          if (w_decide) begin
            if (w_accept) begin
              w_tag_all    = 1'b1;
              w_decide_acc = 1'b1;
              w_state_nxt  = w_flag ? S_IDLE : S_PASS;
            end else begin
              w_drop      = 1'b1;
              w_state_nxt = w_flag ? S_IDLE : S_DISC;
            end
          end else if (w_flag) begin
            w_drop      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_PASS: begin
        if (!i_data_wr) begin
          w_force_prev = 1'b1;
          w_err        = 1'b1;
          w_state_nxt  = S_DISC;
        end else begin
          w_store    = 1'b1;
          w_pass_new = 1'b1;
          w_wcnt_nxt = w_wcnt_inc;
          if (w_flag) begin
            w_state_nxt = S_IDLE;
          end else if (w_wcnt_inc == WC_W'(MAX_LEN)) begin
            w_force_new = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = S_DISC;
          end
        end
      end
      default: begin
        if (i_data_wr && w_flag) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_ts_pend <= '0;
      r_rec_ts  <= '0;
      r_tsn     <= 1'b0;
      r_byte0   <= '0;
      r_et_hi   <= '0;
      r_et_lo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_take_ts) begin
        r_ts_pend <= iv_timer;
        r_byte0   <= iv_data[7:0];
      end
      if ((r_state == S_HEAD) && i_data_wr && (r_wcnt == WC_W'(12))) r_et_hi <= iv_data[7:0];
      if ((r_state == S_HEAD) && i_data_wr && (r_wcnt == WC_W'(13))) r_et_lo <= iv_data[7:0];
      // Word 0 reaches the output slot on this same edge, so the frame's timestamp moves with it.
      if (w_decide_acc) begin
        r_rec_ts <= r_ts_pend;
        r_tsn    <= w_tsn;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < HDR_LEN; i++) r_sl_data[i] <= '0;
      r_sl_vld   <= '0;
      r_sl_pass  <= '0;
      r_sl_force <= '0;
      r_sl_sof   <= '0;
    end else begin
      r_sl_data[0]  <= w_store ? iv_data : '0;
      r_sl_vld[0]   <= w_store;
      r_sl_pass[0]  <= w_pass_new | w_tag_all;
      r_sl_force[0] <= w_force_new;
      r_sl_sof[0]   <= w_sof_new;
      // At the decision edge every slot below the output holds this frame's header.
      for (int i = 1; i < HDR_LEN; i++) begin
        r_sl_data[i]  <= r_sl_data[i-1];
        r_sl_vld[i]   <= r_sl_vld[i-1];
        r_sl_pass[i]  <= r_sl_pass[i-1] | w_tag_all;
        r_sl_force[i] <= r_sl_force[i-1] | (w_force_prev && (i == 1));
        r_sl_sof[i]   <= r_sl_sof[i-1];
      end
    end
  end

  assign w_out_vld  = r_sl_vld[HDR_LEN-1] & r_sl_pass[HDR_LEN-1];
  assign w_out_flag = r_sl_data[HDR_LEN-1][DW] | r_sl_force[HDR_LEN-1];
  assign w_out_eof  = w_out_vld & w_out_flag & ~r_sl_sof[HDR_LEN-1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_pulse <= 1'b0;
      r_acc_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_drop_pulse <= w_drop;
      if (w_out_eof) r_acc_cnt  <= sat_inc(r_acc_cnt);
      if (w_drop)    r_drop_cnt <= sat_inc(r_drop_cnt);
      if (w_err)     r_err_cnt  <= sat_inc(r_err_cnt);
    end
  end

  assign ov_data           = w_out_vld ? {w_out_flag, r_sl_data[HDR_LEN-1][DW-1:0]} : '0;
  assign o_data_wr         = w_out_vld;
  assign ov_rec_ts         = r_rec_ts;
  assign o_tsn_en          = r_tsn;
  assign o_pkt_valid_pulse = w_out_eof;
  assign o_pkt_drop_pulse  = r_drop_pulse;
  assign ov_accept_cnt     = r_acc_cnt;
  assign ov_drop_cnt       = r_drop_cnt;
  assign ov_err_cnt        = r_err_cnt;
  assign ov_state          = r_state;

endmodule

// File: tb/tb_pkt_rx_classifier.sv
// Scoreboard bench for pkt_rx_classifier: frame-level reference model pushes expected
// output words; a negedge monitor pops and compares whatever the DUT emits.
module tb_pkt_rx_classifier;
  localparam int H    = 14;
  localparam int ML   = 100;
  localparam int CW   = 4;
  localparam int TSW  = 19;
  localparam logic [15:0] NMAC = 16'h1662;
  localparam logic [15:0] PTP  = 16'h88F7;

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic            port_type;
  logic [1:0]      cfg_finish;
  logic [8:0]      iv_data;
  logic            i_data_wr;
  logic [TSW-1:0]  iv_timer;
  logic [8:0]      ov_data;
  logic            o_data_wr;
  logic [TSW-1:0]  ov_rec_ts;
  logic            o_tsn_en;
  logic            o_pkt_valid_pulse;
  logic            o_pkt_drop_pulse;
  logic [CW-1:0]   ov_accept_cnt;
  logic [CW-1:0]   ov_drop_cnt;
  logic [CW-1:0]   ov_err_cnt;
  logic [1:0]      ov_state;

  pkt_rx_classifier #(.DW(8), .TS_W(TSW), .HDR_LEN(H), .MAX_LEN(ML), .CNT_W(CW),
                      .NMAC_TYPE(NMAC), .PTP_TYPE(PTP)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .port_type(port_type), .cfg_finish(cfg_finish),
    .iv_data(iv_data), .i_data_wr(i_data_wr), .iv_timer(iv_timer),
    .ov_data(ov_data), .o_data_wr(o_data_wr), .ov_rec_ts(ov_rec_ts), .o_tsn_en(o_tsn_en),
    .o_pkt_valid_pulse(o_pkt_valid_pulse), .o_pkt_drop_pulse(o_pkt_drop_pulse),
    .ov_accept_cnt(ov_accept_cnt), .ov_drop_cnt(ov_drop_cnt), .ov_err_cnt(ov_err_cnt),
    .ov_state(ov_state)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [8:0]     data;
    logic [TSW-1:0] ts;
    logic           tsn;
    logic           eof;
    int             cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   drop_seen = 0;
  int   exp_dropp = 0;
  int   exp_acc = 0, exp_drop = 0, exp_err = 0;
  int   tmr_v = 0;
  int   cyc_drv = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (o_pkt_drop_pulse) drop_seen++;
      if (o_data_wr) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected: got data=%h at cycle %0d, required no output", ov_data, cyc);
        end else begin
          e_mon = sbq.pop_front();
          if (ov_data !== e_mon.data || ov_rec_ts !== e_mon.ts || o_tsn_en !== e_mon.tsn ||
              o_pkt_valid_pulse !== e_mon.eof || cyc != e_mon.cyc) begin
            n_bad++;
            $display("FAIL out_word: got data=%h ts=%0d tsn=%b vp=%b cyc=%0d, required data=%h ts=%0d tsn=%b vp=%b cyc=%0d",
                     ov_data, ov_rec_ts, o_tsn_en, o_pkt_valid_pulse, cyc,
                     e_mon.data, e_mon.ts, e_mon.tsn, e_mon.eof, e_mon.cyc);
          end
        end
      end else if (o_pkt_valid_pulse) begin
        n_cmp++;
        n_bad++;
        $display("FAIL valid_pulse_no_data: got pulse at cycle %0d, required none", cyc);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic tick(input logic [8:0] d, input logic wr);
    @(posedge clk_sys);
    #1;
    iv_data   = d;
    i_data_wr = wr;
    tmr_v++;
    iv_timer  = TSW'(tmr_v);
    cyc_drv   = cyc;
  endtask

  task automatic set_cfg(input logic [1:0] c, input logic p);
    tick(9'h0, 1'b0);
    cfg_finish = c;
    port_type  = p;
  endtask

  task automatic drain(input string nm);
    repeat (H + 4) tick(9'h0, 1'b0);
    chk({nm, "_queue_left"}, sbq.size(), 0);
    chk({nm, "_accept_cnt"}, ov_accept_cnt, exp_acc);
    chk({nm, "_drop_cnt"}, ov_drop_cnt, exp_drop);
    chk({nm, "_err_cnt"}, ov_err_cnt, exp_err);
    chk({nm, "_drop_pulses"}, drop_seen, exp_dropp);
    chk({nm, "_state_idle"}, ov_state, 0);
  endtask

  // Reference model: frame outcome from the classification rules, then per-word expectations.
  task automatic send_frame(input int len, input logic [15:0] et, input logic [7:0] b0,
                            input int gap_at, input int rst_at);
    logic [8:0]     w [$];
    logic [7:0]     by;
    logic [TSW-1:0] ts;
    bit             runt_gap, runt, acc, tsn, cut;
    int             n_out;
    exp_t           x;
    for (int k = 0; k < len; k++) begin
      by = (k == 0) ? b0 : (k == 12) ? et[15:8] : (k == 13) ? et[7:0] : 8'($urandom);
      w.push_back({(k == 0 || k == len - 1) ? 1'b1 : 1'b0, by});
    end
    runt_gap = (gap_at >= 1) && (gap_at < H);
    runt     = runt_gap || (len < H);
    acc      = !runt && ((et == NMAC) || (et == PTP && cfg_finish != 2'b00) || cfg_finish[1]);
    tsn      = port_type ? (et == 16'h8100) : b0[7];
    n_out    = len;
    cut      = 1'b0;
    if (acc && gap_at >= H) begin
      n_out = gap_at;
      cut   = 1'b1;
    end else if (acc && len > ML) begin
      n_out = ML;
      cut   = 1'b1;
    end
    ts = '0;
    for (int k = 0; k < len; k++) begin
      if (k == rst_at) begin
        @(posedge clk_sys);
        #1;
        reset_n   = 1'b0;
        i_data_wr = 1'b0;
        iv_data   = '0;
        #1;
        chk("reset_outputs_zero", {ov_data, o_data_wr, ov_rec_ts, o_tsn_en, o_pkt_valid_pulse,
            o_pkt_drop_pulse, ov_accept_cnt, ov_drop_cnt, ov_err_cnt, ov_state}, 0);
        sbq.delete();
        exp_acc = 0; exp_drop = 0; exp_err = 0; exp_dropp = 0; drop_seen = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        return;
      end
      if (k == H + 1 && !runt && len > H + 1 && (gap_at < 0 || gap_at > H))
        chk("state_after_decision", ov_state, acc ? 2 : 3);
      if (k == gap_at) begin
        tick(9'h0, 1'b0);
        if (runt_gap) break;
      end
      tick(w[k], 1'b1);
      if (k == 0) ts = iv_timer;
      if (acc && k < n_out) begin
        x.data = {(k == 0 || k == n_out - 1) ? 1'b1 : 1'b0, w[k][7:0]};
        x.ts   = ts;
        x.tsn  = tsn;
        x.eof  = (k == n_out - 1);
        x.cyc  = cyc_drv + H;
        sbq.push_back(x);
      end
    end
    if (runt || !acc) begin
      exp_drop = sat(exp_drop);
      exp_dropp++;
      if (runt_gap) exp_err = sat(exp_err);
    end else begin
      exp_acc = sat(exp_acc);
      if (cut) exp_err = sat(exp_err);
    end
  endtask

  initial begin
    logic [15:0] ets [4];
    int len, gap, hi, r;
    ets[0] = NMAC; ets[1] = PTP; ets[2] = 16'h8100; ets[3] = 16'h0800;
    reset_n = 1'b0; port_type = 1'b0; cfg_finish = 2'b00;
    iv_data = '0; i_data_wr = 1'b0; iv_timer = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_state", {ov_data, o_data_wr, ov_rec_ts, o_tsn_en, o_pkt_valid_pulse,
        o_pkt_drop_pulse, ov_accept_cnt, ov_drop_cnt, ov_err_cnt, ov_state}, 0);
    reset_n = 1'b1;

    set_cfg(2'b00, 1'b0);
    tmr_v = 99;
    send_frame(64, NMAC, 8'h12, -1, -1);
    drain("nmac64");

    set_cfg(2'b00, 1'b0);
    send_frame(40, PTP, 8'h80, -1, -1);
    set_cfg(2'b01, 1'b0);
    send_frame(40, PTP, 8'h80, -1, -1);
    drain("ptp_cfg");

    set_cfg(2'b10, 1'b1);
    tmr_v = 199;
    send_frame(64, 16'h8100, 8'h00, -1, -1);
    send_frame(64, 16'h0800, 8'hFF, -1, -1);
    drain("tsn_b2b");

    set_cfg(2'b00, 1'b0);
    send_frame(150, NMAC, 8'h01, -1, -1);
    send_frame(20, NMAC, 8'h02, -1, -1);
    drain("truncate");

    send_frame(10, NMAC, 8'h03, -1, -1);
    send_frame(40, NMAC, 8'h04, 30, -1);
    send_frame(20, NMAC, 8'h05, 6, -1);
    drain("runt_gap");

    send_frame(60, NMAC, 8'h06, -1, 20);
    send_frame(30, NMAC, 8'h87, -1, -1);
    drain("reset_mid");

    for (int f = 0; f < 40; f++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick(9'h0, 1'b0);
      if ($urandom_range(0, 3) == 0) tick({1'b0, 8'($urandom)}, 1'b1);
      r = $urandom_range(0, 9);
      len = (r == 0) ? $urandom_range(2, H - 1) : (r == 1) ? $urandom_range(ML + 1, ML + 30)
                                                         : $urandom_range(H, ML);
      hi  = (len - 1 < ML - 1) ? len - 1 : ML - 1;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(1, hi) : -1;
      send_frame(len, ets[$urandom_range(0, 3)], 8'($urandom), gap, -1);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pkt_rx_classifier.md
Name: pkt_rx_classifier

Overview:
Single-clock successor to the receive-side distinguish/filter path, sitting in the network input process after the GMII clock-crossing FIFO reader and in front of the packet input buffer.
It accepts a byte-wide framed stream and buffers the Ethernet header in an HDR_LEN-deep delay line. It classifies each frame (NMAC/PTP/other, TSN), applies cfg_finish admission, truncates oversize frames, drops runt and broken frames, attaches the receive timestamp, and keeps saturating statistics.
Generalised in data width, header depth, maximum length and classification EtherTypes.

Parameters:
DW, 8, payload bits per word; flag bit is bit DW
TS_W, 19, timestamp width
HDR_LEN, 14, delay-line depth in words; minimum 14
MAX_LEN, 2048, maximum frame length in words; longer frames are truncated
CNT_W, 16, statistics counter width
NMAC_TYPE, 16'h1662, NMAC EtherType
PTP_TYPE, 16'h88F7, PTP EtherType

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
port_type  in  1  0: mapped frame format; 1: standard frame format
cfg_finish  in  2  00: accept NMAC only; 01: accept NMAC+PTP; 1x: accept all
iv_data  in  DW+1  bit DW=1 on first and last word of a frame
i_data_wr  in  1  iv_data valid
iv_timer  in  TS_W  free-running local timer
ov_data  out  DW+1  output word, same flag convention
o_data_wr  out  1  ov_data valid
ov_rec_ts  out  TS_W  timestamp of current output frame, valid from its first word to its last word
o_tsn_en  out  1  TSN class of current output frame, valid with ov_rec_ts
o_pkt_valid_pulse  out  1  one cycle with the last word of each accepted frame
o_pkt_drop_pulse  out  1  one cycle per dropped frame
ov_accept_cnt  out  CNT_W  accepted frames
ov_drop_cnt  out  CNT_W  dropped frames
ov_err_cnt  out  CNT_W  truncated or gap-terminated frames
ov_state  out  2  FSM state: 0 IDLE, 1 HEAD, 2 PASS, 3 DISCARD

Behaviour:
- Reset: all outputs 0, counters 0, delay line invalid, FSM IDLE. A reset mid-frame abandons that frame silently; no pulses or counts are produced for it.
- Delay line: shifts every cycle, with per-slot valid and force-tail bits. Latency from input to output is exactly HDR_LEN cycles. Only slots tagged "pass" produce o_data_wr.
- IDLE: a word with i_data_wr=1 and flag=1 starts a frame. Latch iv_timer into ts_pending, set word count to 1, go to HEAD. Words without the flag bit in IDLE are discarded and not counted.
- HEAD: capture byte 0 and bytes 12-13 (EtherType).
  - When word HDR_LEN-1 (0-based) arrives, decide the frame.
  - NMAC if EtherType==NMAC_TYPE. PTP if EtherType==PTP_TYPE.
  - accept = NMAC, or PTP with cfg_finish!=00, or cfg_finish[1]=1.
  - tsn = (EtherType==16'h8100) when port_type=1; tsn = byte0[7] when port_type=0.
  - Accept: tag all buffered slots of the frame as pass and go to PASS. Reject: go to DISCARD.
  - cfg_finish and port_type are sampled at decision time only.
- HEAD runt: a tail (flag=1) or an i_data_wr gap before the decision drops the frame: drop pulse, drop_cnt+1, back to IDLE, no output. A gap-terminated runt also adds err_cnt+1.
- PASS: words are tagged pass.
  - Tail: on flag=1, go to IDLE.
  - Gap: i_data_wr=0 inside a frame sets force-tail on the newest buffered slot; err_cnt+1; go to DISCARD, waiting for the tail.
  - Truncation: when word count reaches MAX_LEN without a tail, that word is output with flag forced to 1; err_cnt+1; go to DISCARD.
- DISCARD: consume words until flag=1, then go to IDLE. A rejected frame gives drop pulse and drop_cnt+1 at its decision cycle.
- Output frame: ts_pending moves to ov_rec_ts, and tsn to o_tsn_en, when the frame's first pass word exits; both hold until the next first word. On the exiting last pass word, pulse o_pkt_valid_pulse and accept_cnt+1.
- Back-to-back frames: a head may arrive the cycle after a tail. ts_pending is double-buffered so a new head never corrupts the timestamp of a frame still in the delay line.
- Counters saturate at all-ones. Word count is width clog2(MAX_LEN)+1. Simultaneous drop and accept events in one cycle are both counted.

Test Plan:
- cfg_finish=00, 64-byte frame with EtherType 1662, iv_timer=100 at head -> 64 output words starting 14 cycles later, flags on words 0 and 63, ov_rec_ts=100, one valid pulse, accept_cnt=1.
- cfg_finish=00, then 01, PTP 88F7 frame -> first dropped (drop_cnt=1, no o_data_wr); second passed.
- port_type=1, cfg_finish=10, EtherType 8100 frame immediately followed by an IPv4 frame -> o_tsn_en=1 then 0, timestamps 200 and 264 (distinct), two pulses.
- MAX_LEN=100, 150-word frame -> exactly 100 output words, word 99 flag=1, err_cnt=1, next frame accepted normally.
- 10-word runt, then a 40-word frame with i_data_wr low at word 30 -> runt dropped (drop_cnt=1); second frame outputs 30 words ending with forced tail, err_cnt=1.
- Reset asserted at word 20 of an accepted frame -> all outputs 0 immediately, counters 0, the next frame is processed cleanly.
